// File: rtl/speed_tick_scheduler.sv
// speed_tick_scheduler
// Turns single-cycle faster/slower requests from the speed-key FSM into a
// saturating speed level, and emits a one-cycle oTICK whose period halves
// with each level (TC = BASE_DIV >> level).
// Optional feature: define SPEED_PAUSE_EN to add iPAUSE. While it is high the
// divider freezes and no ticks are issued. Level requests are still handled.
module speed_tick_scheduler #(
  parameter int LEVELS   = 8,
  parameter int BASE_DIV = 50_000_000,
  parameter int DEF_LVL  = 0,
  parameter int CNT_W    = 26,
  parameter int LVL_W    = 3
) (
  input  logic             iCLK,
  input  logic             iRST_n,
  input  logic             iENABLE,
  input  logic             iUP_DOWN,
`ifdef SPEED_PAUSE_EN
  input  logic             iPAUSE,
`endif
  output logic             oTICK,
  output logic [LVL_W-1:0] oLEVEL,
  output logic             oAT_MAX,
  output logic             oAT_MIN,
  output logic             oREJECT
);

  localparam logic [LVL_W-1:0] MAX_LVL = LVL_W'(LEVELS - 1);
  localparam logic [LVL_W-1:0] RST_LVL = LVL_W'(DEF_LVL);
  localparam logic [31:0]      BASE_W  = 32'(BASE_DIV);

  logic [LVL_W-1:0] lvl;
  logic [LVL_W-1:0] lvlNext;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cntNext;
  logic [CNT_W-1:0] tcLast;
  logic [31:0]      tcFull;
  logic             tickQ;
  logic             tickNext;
  logic             rejectQ;
  logic             rejectNext;
  logic             atMax;
  logic             atMin;
  logic             atTc;
  logic             levelChange;
  logic             paused;

`ifdef SPEED_PAUSE_EN
  assign paused = iPAUSE;
`else
  assign paused = 1'b0;
`endif

  // State register: level, divider count and the two registered pulses.
  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      lvl     <= RST_LVL;
      cnt     <= '0;
      tickQ   <= 1'b0;
      rejectQ <= 1'b0;
    end else begin
      lvl     <= lvlNext;
      cnt     <= cntNext;
      tickQ   <= tickNext;
      rejectQ <= rejectNext;
    end
  end

  // Next-state logic: saturating level steps and a divider that restarts on any level change.
  always_comb begin
    lvlNext     = lvl;
    levelChange = 1'b0;
    rejectNext  = 1'b0;
    tcFull      = BASE_W >> lvl;
    tcLast      = CNT_W'(tcFull - 32'd1);
    atTc        = (cnt == tcLast);

    if (iENABLE) begin
      if (iUP_DOWN) begin
        if (!atMax) begin
          lvlNext     = lvl + 1'b1;
          levelChange = 1'b1;
        end else begin
          rejectNext = 1'b1;
        end
      end else begin
        if (!atMin) begin
          lvlNext     = lvl - 1'b1;
          levelChange = 1'b1;
        end else begin
          rejectNext = 1'b1;
        end
      end
    end

    if (paused) begin
      tickNext = 1'b0;
      cntNext  = levelChange ? '0 : cnt;
    end else begin
      tickNext = atTc;
      if (levelChange || atTc) begin
        cntNext = '0;
      end else begin
        cntNext = cnt + 1'b1;
      end
    end
  end

  // Outputs: all decoded directly from registered state.
  always_comb begin
    atMax   = (lvl == MAX_LVL);
    atMin   = (lvl == '0);
    oLEVEL  = lvl;
    oAT_MAX = atMax;
    oAT_MIN = atMin;
    oTICK   = tickQ;
    oREJECT = rejectQ;
  end

endmodule
